truth_table_sweeper: RTL

- Hardware exhaustive-stimulus engine for combinational lab DUTs; the synthesizable, self-checking successor to the software for-loop sweep.
- Drives every input combination 0..2**N_VARS-1 onto an N_VARS-bit vector, holds each for HOLD_CYCLES, samples the DUT's 1-bit response and compares it against a parameterised expected truth table.
- Reports mismatch count, first failing vector, captured truth table and pass/done status.
- Sits between the DUT and the lab top or board LEDs.

---
 rtl/truth_table_sweeper.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Exhaustive stimulus engine; walks every input combination of a
//               combinational DUT and scores its response against a truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int                     N_VARS      = 3,
    parameter int                     HOLD_CYCLES = 1,
    parameter logic [2**N_VARS-1:0]   EXPECT      = 8'b1110_1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   dut_y,
    output logic [N_VARS-1:0]      vec,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_VARS:0]        err_count,
    output logic [N_VARS-1:0]      first_fail,
    output logic                   fail_valid,
    output logic [2**N_VARS-1:0]   captured
);

    localparam int NVEC = 2**N_VARS;
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [N_VARS-1:0] VEC_LAST  = N_VARS'(NVEC - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_VARS-1:0]   vec_q, vec_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_VARS:0]     err_q, err_d;
    logic [N_VARS-1:0]   ff_q, ff_d;
    logic                fv_q, fv_d;
    logic [NVEC-1:0]     cap_q, cap_d;
    logic                w_mismatch;

    assign w_mismatch = dut_y ^ EXPECT[vec_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        cap_d   = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SWEEP;
                    vec_d   = '0;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    cap_d   = '0;
                end
            end
            ST_SWEEP: begin
                // Abort wins over a coincident sample edge; that sample is dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    cap_d[vec_q] = dut_y;
                    hold_d       = '0;
                    if (w_mismatch) begin
                        err_d = err_q + (N_VARS+1)'(1);
                        if (!fv_q) begin
                            ff_d = vec_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        vec_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + N_VARS'(1);
                    end
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                vec_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;
    assign captured   = cap_q;

endmodule
`default_nettype wire
